adc_scan_sequencer: RTL
=======================

# adc_scan_sequencer

Sequencer for the two serial ADCs on the DE4 board. The ADCs share AD_SCLK and AD_DIN and have separate DOUT/SSTRB lines. The block steps through an enabled channel mask, issues one conversion command per channel to both ADCs at once, waits for both end-of-conversion strobes, and shifts in both 16-bit results in parallel. Each channel pair is handed to the Avalon/PCIe side through a valid/ready handshake. It sits inside the `adc` conduit component of the Qsys system, between the board pins and the sample DMA path.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range 1..255.
- MODE, 4'b0000: low 4 bits of every command word.
- STRB_TIMEOUT, 4095: clk cycles allowed in WAIT_STRB before the conversion is abandoned; legal range 1..65535.

- clk  in  1  system clock, 50 MHz from the PCIe/Qsys clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; scanning runs while high.
- ch_mask  in  8  channel enable mask; bit i enables channel i.
- busy  out  1  high whenever the FSM is not in IDLE.
- sample_valid  out  1  result pair available.
- sample_ready  in  1  consumer accepts the pair.
- sample_ch  out  3  channel of the current pair.
- sample_data0  out  16  ADC0 result.
- sample_data1  out  16  ADC1 result.
- strb_timeout  out  1  one-cycle pulse on an abandoned conversion.
- ad_din  out  1  shared command line.
- ad_sclk  out  1  shared serial clock.
- ad_dout0, ad_dout1  in  1  serial data, asynchronous to clk.
- ad_sstrb0, ad_sstrb1  in  1  end-of-conversion strobes, asynchronous to clk.

## Operation
- ad_dout0/1 and ad_sstrb0/1 each pass through a 2-FF synchronizer; all logic below uses the synchronized versions.
- Command word, 8 bits, sent MSB first: {1'b1, ch[2:0], MODE[3:0]}.
- FSM states: IDLE, CMD, WAIT_STRB, READ, HOLD.
- IDLE:
  - When enable=1 and ch_mask≠0, select the next set bit of ch_mask strictly after last_ch, searching circularly.
  - Latch the selected channel into cur_ch and go to CMD.
  - last_ch resets to 7, so the first channel scanned is the lowest set bit.
  - ch_mask is sampled only at this point.
- CMD:
  - Send 8 SCLK pulses.
  - ad_din changes only during the SCLK-low phase; the ADC samples it on the SCLK rising edge.
  - After the 8th low phase, go to WAIT_STRB with SCLK low.
- WAIT_STRB:
  - SCLK is held low.
  - A 16-bit counter runs from 0.
  - When both synchronized strobes are high, go to READ.
  - If the counter reaches STRB_TIMEOUT first:
    - Pulse strb_timeout.
    - Set last_ch to cur_ch.
    - Return to IDLE; no sample is produced.
- READ:
  - Send 16 SCLK pulses, ad_din=0.
  - On the last clk of each high phase, shift the synchronized dout0/dout1 into two 16-bit registers, MSB first.
  - After the 16th low phase, load the sample_* outputs, set last_ch to cur_ch, and go to HOLD.
- HOLD:
  - sample_valid=1.
  - sample_ch, sample_data0 and sample_data1 stay stable until sample_valid·sample_ready.
  - On acceptance, go to IDLE. IDLE re-evaluates enable in that same following cycle.
- Stopping: enable is checked only in IDLE, so dropping enable mid-scan completes the current conversion, including HOLD, before stopping.
- Unhandled combinations: an all-zero ch_mask keeps the block in IDLE. A single set bit rescans the same channel.

## Timing
- Reset values:
  - ad_sclk=0, ad_din=0.
  - sample_valid=0, sample_ch=0, sample_data0=0, sample_data1=0.
  - strb_timeout=0, busy=0.
  - FSM=IDLE, last_ch=7.
- A reset asserted mid-transfer returns all of these immediately. There is no flush or partial-sample output.
- SCLK period is 2·CLK_DIV clk cycles, with low phase first, then high phase.
- CMD lasts 16·CLK_DIV cycles. READ lasts 32·CLK_DIV cycles.
- Synchronizer latency is 2 cycles, so WAIT_STRB sees a strobe edge 2–3 clk cycles after the pin changes.
- IDLE→CMD takes 1 cycle. sample_valid rises the cycle after READ ends.
- Minimum scan period per channel with CLK_DIV=2 and sample_ready tied high: 1 (IDLE) + 32 (CMD) + conversion + 3 (sync) + 64 (READ) + 1 (HOLD) cycles.
- strb_timeout is high for exactly one cycle: the cycle the counter equals STRB_TIMEOUT.

## Structure
- Shared package adc_seq_pkg holds:
  - the state encoding;
  - CMD_BITS=8 and DATA_BITS=16;
  - a next-channel function (circular priority search over 8 bits);
  - a command-word build function.
- Sub-module sclk_bit_timer:
  - Input: go.
  - Parameters: CLK_DIV and the number of bits.
  - Outputs: ad_sclk, a low-phase-start strobe (shift DIN), a high-phase-end strobe (sample DOUT), and done.
  - CMD and READ each reuse it with a different bit count.

## Test plan
- Single channel: CLK_DIV=2, ch_mask=8'h04, ADC models return 16'hA5C3 / 16'h3C5A.
  - Required: ad_din carries 8'b1010_0000.
  - Required: sample_ch=2, data0=16'hA5C3, data1=16'h3C5A.
  - Required: SCLK period is 4 clk cycles.
- Scan order: ch_mask=8'h91.
  - Required: channels 0, 4, 7, 0, 4 in that order.
  - Then change the mask to 8'h06 while channel 4 is in READ. Required: the next channel is 1, then 2.
- Backpressure: sample_ready held low for 50 cycles.
  - Required: sample_valid and the data stay stable, ad_sclk stays low, no new command is issued.
  - Required: the first command starts 1 cycle after acceptance.
- Timeout: ad_sstrb1 never asserts, STRB_TIMEOUT=100.
  - Required: one strb_timeout pulse after 100 WAIT_STRB cycles, no sample_valid, and the scan advances to the next channel.
- Reset and enable: assert reset in the middle of READ.
  - Required: all outputs return to their reset values in the same cycle.
  - After release with ch_mask=8'h80, the first channel is 7.
  - Deassert enable during CMD. Required: that conversion completes and is delivered, then busy goes to 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the dual-ADC scan sequencer.
// State encoding, word sizes, channel search and command build.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_STRB,
    S_READ,
    S_HOLD
  } state_t;

  localparam int CMD_BITS  = 8;
  localparam int DATA_BITS = 16;

  // Circular search for the first set bit strictly after last;
  // last itself is tried last, so a single-bit mask repeats.
  function automatic logic [2:0] next_ch(
    input logic [7:0] mask,
    input logic [2:0] last
  );
    logic [2:0] idx;
    logic [2:0] sel;
    logic       found;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [CMD_BITS-1:0] cmd_word(
    input logic [2:0] ch,
    input logic [3:0] mode
  );
    return {1'b1, ch, mode};
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_sclk.sv
// SCLK generator: NBITS pulses, low phase first, CLK_DIV clk per half.
// Counters clear whenever go is low, so each burst starts fresh.
module sclk_bit_timer #(
  parameter int CLK_DIV = 2,
  parameter int NBITS   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic ad_sclk,
  output logic low_start,
  output logic high_end,
  output logic done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          phase;
  logic          div_end;

  assign div_end = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (!go) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_end) begin
      div_cnt <= '0;
      phase   <= ~phase;
      if (phase) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign ad_sclk   = phase;
  assign low_start = go && !phase && (div_cnt == '0);
  assign high_end  = go && phase && div_end;
  assign done      = high_end && (bit_cnt == BW'(NBITS - 1));

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans enabled channels on two serial ADCs in lockstep and
// hands each result pair out over a valid/ready handshake.
import adc_seq_pkg::*;

module adc_scan_sequencer #(
  parameter int         CLK_DIV      = 2,
  parameter logic [3:0] MODE         = 4'b0000,
  parameter int         STRB_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        busy,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [2:0]  sample_ch,
  output logic [15:0] sample_data0,
  output logic [15:0] sample_data1,
  output logic        strb_timeout,
  output logic        ad_din,
  output logic        ad_sclk,
  input  logic        ad_dout0,
  input  logic        ad_dout1,
  input  logic        ad_sstrb0,
  input  logic        ad_sstrb1
);

  state_t                 state;
  logic [2:0]             last_ch;
  logic [2:0]             cur_ch;
  logic [CMD_BITS-1:0]    cmd_sr;
  logic [DATA_BITS-2:0]   sh0;
  logic [DATA_BITS-2:0]   sh1;
  logic [15:0]            wcnt;
  logic [3:0]             sync1;
  logic [3:0]             sync2;
  logic [2:0]             nxt_ch;
  logic [CMD_BITS-1:0]    nxt_cmd;
  logic cmd_sclk, cmd_high_end, cmd_done, cmd_low_unused;
  logic rd_sclk, rd_high_end, rd_done, rd_low_unused;
  logic dout0_s, dout1_s, strb0_s, strb1_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ad_dout1, ad_dout0, ad_sstrb1, ad_sstrb0};
      sync2 <= sync1;
    end
  end

  assign {dout1_s, dout0_s, strb1_s, strb0_s} = sync2;

  assign nxt_ch  = next_ch(ch_mask, last_ch);
  assign nxt_cmd = cmd_word(nxt_ch, MODE);

  sclk_bit_timer #(.CLK_DIV(CLK_DIV), .NBITS(CMD_BITS)) u_cmd (
    .clk       (clk),
    .rst       (reset),
    .go        (state == S_CMD),
    .ad_sclk   (cmd_sclk),
    .low_start (cmd_low_unused),
    .high_end  (cmd_high_end),
    .done      (cmd_done)
  );

  sclk_bit_timer #(.CLK_DIV(CLK_DIV), .NBITS(DATA_BITS)) u_read (
    .clk       (clk),
    .rst       (reset),
    .go        (state == S_READ),
    .ad_sclk   (rd_sclk),
    .low_start (rd_low_unused),
    .high_end  (rd_high_end),
    .done      (rd_done)
  );

  assign ad_sclk = cmd_sclk | rd_sclk;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      last_ch      <= 3'd7;
      cur_ch       <= '0;
      cmd_sr       <= '0;
      sh0          <= '0;
      sh1          <= '0;
      wcnt         <= '0;
      ad_din       <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data0 <= '0;
      sample_data1 <= '0;
      strb_timeout <= 1'b0;
    end else begin
      strb_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enable && ch_mask != '0) begin
            cur_ch <= nxt_ch;
            ad_din <= nxt_cmd[CMD_BITS-1];
            cmd_sr <= {nxt_cmd[CMD_BITS-2:0], 1'b0};
            state  <= S_CMD;
          end
        end
        // DIN moves on the edge that ends a high phase,
        // i.e. exactly as the next low phase begins.
        S_CMD: begin
          if (cmd_done) begin
            ad_din <= 1'b0;
            wcnt   <= '0;
            state  <= S_WAIT_STRB;
          end else if (cmd_high_end) begin
            ad_din <= cmd_sr[CMD_BITS-1];
            cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
          end
        end
        S_WAIT_STRB: begin
          wcnt <= wcnt + 1'b1;
          if (strb0_s && strb1_s) begin
            state <= S_READ;
          end else if (wcnt == 16'(STRB_TIMEOUT - 1)) begin
            strb_timeout <= 1'b1;
            last_ch      <= cur_ch;
            state        <= S_IDLE;
          end
        end
        S_READ: begin
          if (rd_high_end) begin
            sh0 <= {sh0[DATA_BITS-3:0], dout0_s};
            sh1 <= {sh1[DATA_BITS-3:0], dout1_s};
          end
          if (rd_done) begin
            sample_data0 <= {sh0, dout0_s};
            sample_data1 <= {sh1, dout1_s};
            sample_ch    <= cur_ch;
            sample_valid <= 1'b1;
            last_ch      <= cur_ch;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
